adam_rst_seq: RTL and testbench

ADAM_RST_SEQ -- requirements
Module: adam_rst_seq

---
 rtl/adam_rst_seq.sv | 137 +++++++++++++
 tb/tb_adam_rst_seq.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/adam_rst_seq.sv
// Reset sequencer: synchronizes board reset release, then releases the low-speed
// domain, JTAG TAP and high-speed domain in order; supports a soft-reset request in RUN.
module adam_rst_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ext_rst_req,
  output logic       lsdom_rst,
  output logic       hsdom_rst,
  output logic       trst_n,
  output logic       rst_done,
  output logic [1:0] rst_cause
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("adam_rst_seq: SYNC_STAGES must be in 2..4");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("adam_rst_seq: HOLD_CYCLES must be in 1..255");
  end
  if (GAP_CYCLES < 0 || GAP_CYCLES > 255) begin : g_bad_gap
    $error("adam_rst_seq: GAP_CYCLES must be in 0..255");
  end

  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

  localparam logic [1:0] CAUSE_PIN  = 2'b01;
  localparam logic [1:0] CAUSE_SOFT = 2'b10;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_LS_UP = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rst_sync;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lsdom_q, lsdom_d;
  logic          hsdom_q, hsdom_d;
  logic          trst_q, trst_d;
  logic          done_q, done_d;
  logic [1:0]    cause_q, cause_d;

  // Release synchronizer: asserts instantly with rst, deasserts SYNC_STAGES edges later.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, exactly like the hardware shift chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
  end

  assign rst_sync = sync_q[SYNC_STAGES-1];

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;

    unique case (state_q)
      ST_HOLD: begin
        if (rst_sync) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = (GAP_CYCLES > 0) ? ST_LS_UP : ST_RUN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_LS_UP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RUN: begin
        if (ext_rst_req) begin
          cnt_d   = '0;
          cause_d = CAUSE_SOFT;
          state_d = ST_HOLD;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_HOLD;
      end
    endcase

    // Outputs are registered from the next state so they change on the transition edge.
    lsdom_d = (state_d == ST_HOLD);
    hsdom_d = (state_d != ST_RUN);
    done_d  = (state_d == ST_RUN);
    // TAP reset leaves only with the pin reset, so debug survives a soft reset.
    trst_d  = trst_q | (state_d != ST_HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      lsdom_q <= 1'b1;
      hsdom_q <= 1'b1;
      trst_q  <= 1'b0;
      done_q  <= 1'b0;
      cause_q <= CAUSE_PIN;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lsdom_q <= lsdom_d;
      hsdom_q <= hsdom_d;
      trst_q  <= trst_d;
      done_q  <= done_d;
      cause_q <= cause_d;
    end
  end

  assign lsdom_rst = lsdom_q;
  assign hsdom_rst = hsdom_q;
  assign trst_n    = trst_q;
  assign rst_done  = done_q;
  assign rst_cause = cause_q;

endmodule

// File: tb/tb_adam_rst_seq.sv
// Directed bench for adam_rst_seq: default instance for release timing, soft reset
// and glitch abort; a HOLD=1/GAP=0 instance for the collapsed sequence.
module tb_adam_rst_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req = 1'b0;
  logic rst_f = 1'b0;
  logic req_f = 1'b0;

  logic       lsdom, hsdom, trst_n, done;
  logic [1:0] cause;
  logic       lsdom_f, hsdom_f, trst_n_f, done_f;
  logic [1:0] cause_f;

  int n_checks = 0;
  int n_fail   = 0;

  // Pattern layout: {lsdom_rst, hsdom_rst, trst_n, rst_done, rst_cause[1:0]}
  localparam logic [5:0] P_PIN_HOLD  = 6'b110001;
  localparam logic [5:0] P_PIN_LS    = 6'b011001;
  localparam logic [5:0] P_PIN_RUN   = 6'b001101;
  localparam logic [5:0] P_SOFT_HOLD = 6'b111010;
  localparam logic [5:0] P_SOFT_LS   = 6'b011010;
  localparam logic [5:0] P_SOFT_RUN  = 6'b001110;

  always #5 clk = ~clk;

  adam_rst_seq u_dut (
    .clk         (clk),
    .rst         (rst),
    .ext_rst_req (req),
    .lsdom_rst   (lsdom),
    .hsdom_rst   (hsdom),
    .trst_n      (trst_n),
    .rst_done    (done),
    .rst_cause   (cause)
  );

  adam_rst_seq #(.SYNC_STAGES(2), .HOLD_CYCLES(1), .GAP_CYCLES(0)) u_fast (
    .clk         (clk),
    .rst         (rst_f),
    .ext_rst_req (req_f),
    .lsdom_rst   (lsdom_f),
    .hsdom_rst   (hsdom_f),
    .trst_n      (trst_n_f),
    .rst_done    (done_f),
    .rst_cause   (cause_f)
  );

  function automatic logic [5:0] pat();
    return {lsdom, hsdom, trst_n, done, cause};
  endfunction

  function automatic logic [5:0] pat_f();
    return {lsdom_f, hsdom_f, trst_n_f, done_f, cause_f};
  endfunction

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Async assertion before any clock edge.
    #1 rst = 1'b1; rst_f = 1'b1;
    #1;
    check("por_async", pat(), P_PIN_HOLD);
    check("fast_por_async", pat_f(), P_PIN_HOLD);
    edges(3);
    check("por_held", pat(), P_PIN_HOLD);

    // Release; next rising edge is E1.
    rst = 1'b0;
    edges(4);
    req = 1'b1;                      // seen at E5 while in HOLD
    edges(1);
    req = 1'b0;
    check("hold_req_ignored", pat(), P_PIN_HOLD);
    edges(12);
    check("pin_e17", pat(), P_PIN_HOLD);
    edges(1);
    check("pin_e18_ls_up", pat(), P_PIN_LS);
    req = 1'b1;                      // seen at E19 while in LS_UP
    edges(1);
    req = 1'b0;
    check("ls_req_ignored", pat(), P_PIN_LS);
    edges(2);
    check("pin_e21", pat(), P_PIN_LS);
    edges(1);
    check("pin_e22_run", pat(), P_PIN_RUN);
    edges(3);
    check("run_stable", pat(), P_PIN_RUN);

    // Soft reset from RUN: request edge R.
    req = 1'b1;
    edges(1);
    req = 1'b0;
    check("soft_r", pat(), P_SOFT_HOLD);
    edges(15);
    check("soft_r15", pat(), P_SOFT_HOLD);
    edges(1);
    check("soft_r16_ls_up", pat(), P_SOFT_LS);
    edges(3);
    check("soft_r19", pat(), P_SOFT_LS);
    edges(1);
    check("soft_r20_run", pat(), P_SOFT_RUN);

    // rst and ext_rst_req together in RUN: pin reset wins.
    rst = 1'b1; req = 1'b1;
    #2;
    check("both_async", pat(), P_PIN_HOLD);
    edges(1);
    check("both_edge", pat(), P_PIN_HOLD);
    rst = 1'b0; req = 1'b0;
    edges(18);
    check("rerun_e18_ls_up", pat(), P_PIN_LS);
    edges(1);
    check("rerun_e19_ls_up", pat(), P_PIN_LS);

    // Sub-cycle glitch between edges while in LS_UP.
    #3 rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("glitch_abort", pat(), P_PIN_HOLD);
    edges(17);
    check("glitch_e17", pat(), P_PIN_HOLD);
    edges(1);
    check("glitch_e18_ls_up", pat(), P_PIN_LS);
    edges(3);
    check("glitch_e21", pat(), P_PIN_LS);
    edges(1);
    check("glitch_e22_run", pat(), P_PIN_RUN);

    // HOLD=1, GAP=0: both domains and TAP release together at E3.
    check("fast_held", pat_f(), P_PIN_HOLD);
    rst_f = 1'b0;
    edges(2);
    check("fast_e2", pat_f(), P_PIN_HOLD);
    edges(1);
    check("fast_e3_run", pat_f(), P_PIN_RUN);
    req_f = 1'b1;
    edges(1);
    req_f = 1'b0;
    check("fast_soft_r", pat_f(), P_SOFT_HOLD);
    edges(1);
    check("fast_soft_r1_run", pat_f(), P_SOFT_RUN);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
